// File: rtl/thread_fetch_scheduler_pkg.sv
// Shared constants and the thread-ID type used by the fetch scheduler and the downstream pipe registers.
// Defaults give four threads with a 9-bit instruction address.
package thread_fetch_scheduler_pkg;

  localparam int DEF_INST_ADDR_WIDTH = 9;
  localparam int DEF_THREAD_BITS     = 2;
  localparam int DEF_NUM_THREADS     = 2 ** DEF_THREAD_BITS;

  typedef logic [DEF_THREAD_BITS-1:0] thread_id_t;

endpackage

// File: rtl/thread_fetch_scheduler_rr_thread_select.sv
// Finds the first set bit in mask, searching circularly from last+1; grant_valid is low when mask is empty.
// Purely combinational (0 cycles); it has no flow control.
module rr_thread_select #(
  parameter int THREAD_BITS = 2
) (
  input  logic [(2**THREAD_BITS)-1:0] mask,
  input  logic [THREAD_BITS-1:0]      last,
  output logic [THREAD_BITS-1:0]      grant_id,
  output logic                        grant_valid
);

  localparam int NUM_THREADS = 2 ** THREAD_BITS;

  logic [THREAD_BITS-1:0] idx;

  // Offsets 1..NUM_THREADS, so last itself is tried only after every other thread.
  always_comb begin
    grant_id    = '0;
    grant_valid = 1'b0;
    idx         = '0;
    for (int i = 1; i <= NUM_THREADS; i++) begin
      idx = last + THREAD_BITS'(i);
      if (!grant_valid && mask[idx]) begin
        grant_valid = 1'b1;
        grant_id    = idx;
      end
    end
  end

endmodule

// File: rtl/thread_fetch_scheduler.sv
// Round-robin fetch scheduler: one PC per thread; each stall-free cycle it issues one enabled thread.
// Outputs are registered one cycle after selection; stall freezes issue, pipe_en = ~stall, and redirects still apply.
module thread_fetch_scheduler
  import thread_fetch_scheduler_pkg::*;
#(
  parameter int INST_ADDR_WIDTH = DEF_INST_ADDR_WIDTH,
  parameter int THREAD_BITS     = DEF_THREAD_BITS
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          stall,
  input  logic [(2**THREAD_BITS)-1:0]   thread_en,
  input  logic                          redirect_valid,
  input  logic [THREAD_BITS-1:0]        redirect_thread,
  input  logic [INST_ADDR_WIDTH-1:0]    redirect_addr,
  output logic [THREAD_BITS-1:0]        thread_id_out,
  output logic [INST_ADDR_WIDTH-1:0]    inst_addr_out,
  output logic                          fetch_valid,
  output logic                          pipe_en
);

  localparam int NUM_THREADS = 2 ** THREAD_BITS;

  logic [INST_ADDR_WIDTH-1:0] pc [NUM_THREADS];
  logic [THREAD_BITS-1:0]     last;
  logic [THREAD_BITS-1:0]     grant_id;
  logic                       grant_valid;

  rr_thread_select #(
    .THREAD_BITS (THREAD_BITS)
  ) u_select (
    .mask        (thread_en),
    .last        (last),
    .grant_id    (grant_id),
    .grant_valid (grant_valid)
  );

  assign pipe_en = ~stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_THREADS; i++) begin
        pc[i] <= '0;
      end
      last          <= '1;
      thread_id_out <= '0;
      inst_addr_out <= '0;
      fetch_valid   <= 1'b0;
    end else begin
      if (!stall) begin
        if (grant_valid) begin
          thread_id_out <= grant_id;
          inst_addr_out <= pc[grant_id];
          fetch_valid   <= 1'b1;
          last          <= grant_id;
          pc[grant_id]  <= pc[grant_id] + 1'b1;
        end else begin
          fetch_valid   <= 1'b0;
        end
      end
      // Placed after the increment so a same-cycle redirect of the issuing thread wins.
      if (redirect_valid) begin
        pc[redirect_thread] <= redirect_addr;
      end
    end
  end

endmodule

// File: tb/tb_thread_fetch_scheduler.sv
// Scoreboard bench: stimulus pushes the reference model's expected outputs, a monitor pops and compares each cycle.
module tb_thread_fetch_scheduler;
  import thread_fetch_scheduler_pkg::*;

  localparam int AW = 9;
  localparam int TB = 2;
  localparam int NT = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            stall;
  logic [NT-1:0]   thread_en;
  logic            redirect_valid;
  logic [TB-1:0]   redirect_thread;
  logic [AW-1:0]   redirect_addr;
  thread_id_t      thread_id_out;
  logic [AW-1:0]   inst_addr_out;
  logic            fetch_valid;
  logic            pipe_en;

  thread_fetch_scheduler #(
    .INST_ADDR_WIDTH (AW),
    .THREAD_BITS     (TB)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .thread_en       (thread_en),
    .redirect_valid  (redirect_valid),
    .redirect_thread (redirect_thread),
    .redirect_addr   (redirect_addr),
    .thread_id_out   (thread_id_out),
    .inst_addr_out   (inst_addr_out),
    .fetch_valid     (fetch_valid),
    .pipe_en         (pipe_en)
  );

  always #5 clk = ~clk;

  typedef struct {
    int tid;
    int addr;
    bit vld;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Reference model state: PC per thread, last issued thread, visible outputs.
  int m_pc [NT];
  int m_last;
  int m_tid;
  int m_addr;
  bit m_vld;

  function automatic void model_step(bit rst, bit stl, logic [NT-1:0] en,
                                     bit rv, int rt, int ra);
    bit found;
    int t;
    if (rst) begin
      for (int i = 0; i < NT; i++) m_pc[i] = 0;
      m_last = NT - 1;
      m_tid  = 0;
      m_addr = 0;
      m_vld  = 0;
      return;
    end
    if (!stl) begin
      found = 0;
      for (int k = 1; k <= NT; k++) begin
        t = (m_last + k) % NT;
        if (!found && en[t]) begin
          found  = 1;
          m_tid  = t;
          m_addr = m_pc[t];
          m_last = t;
          m_pc[t] = (m_pc[t] + 1) % (1 << AW);
        end
      end
      m_vld = found;
    end
    if (rv) m_pc[rt] = ra;
  endfunction

  // Drive one cycle of inputs at the falling edge and queue the expected registered result.
  task automatic drive(bit rst, bit stl, logic [NT-1:0] en, bit rv, int rt, int ra);
    exp_t e;
    reset           = rst;
    stall           = stl;
    thread_en       = en;
    redirect_valid  = rv;
    redirect_thread = TB'(rt);
    redirect_addr   = AW'(ra);
    model_step(rst, stl, en, rv, rt, ra);
    e.tid  = m_tid;
    e.addr = m_addr;
    e.vld  = m_vld;
    exp_q.push_back(e);
    #1;
    total++;
    if (pipe_en !== !stl) begin
      bad++;
      $display("FAIL pipe_en cyc=%0d got=%b exp=%b", cyc, pipe_en, !stl);
    end
    @(negedge clk);
  endtask

  task automatic run(int n, bit stl, logic [NT-1:0] en);
    for (int i = 0; i < n; i++) drive(0, stl, en, 0, 0, 0);
  endtask

  // Monitor: samples just after each rising edge and checks against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL scoreboard_underflow cyc=%0d got=empty exp=entry", cyc);
      end else begin
        e = exp_q.pop_front();
        if (thread_id_out !== TB'(e.tid) || inst_addr_out !== AW'(e.addr) ||
            fetch_valid !== e.vld) begin
          bad++;
          $display("FAIL issue cyc=%0d got tid=%0d addr=%h vld=%b exp tid=%0d addr=%h vld=%b",
                   cyc, thread_id_out, inst_addr_out, fetch_valid, e.tid, e.addr, e.vld);
        end
      end
    end
  end

  initial begin
    reset = 1; stall = 0; thread_en = '0;
    redirect_valid = 0; redirect_thread = '0; redirect_addr = '0;

    // Reset, then all four threads enabled: 0,1,2,3,0,1,2,3 at addresses 0,0,0,0,1,1,1,1.
    drive(1, 0, 4'b0000, 0, 0, 0);
    drive(1, 0, 4'b1111, 0, 0, 0);
    run(8, 0, 4'b1111);

    // Alternating mask, then an empty mask holding PCs, then resume.
    drive(1, 0, 4'b1010, 0, 0, 0);
    run(4, 0, 4'b1010);
    run(3, 0, 4'b0000);
    run(3, 0, 4'b1010);

    // Three-cycle stall in mid-stream, then resume in order.
    run(2, 0, 4'b1111);
    run(3, 1, 4'b1111);
    run(4, 0, 4'b1111);

    // Redirect thread 2 to 0x1F0 in the cycle it is selected.
    drive(1, 0, 4'b1111, 0, 0, 0);
    run(2, 0, 4'b1111);
    drive(0, 0, 4'b1111, 1, 2, 'h1F0);
    run(5, 0, 4'b1111);

    // Single thread, redirect to 0x1FF: next issues 0x1FF then wrap to 0x000.
    drive(1, 0, 4'b0001, 0, 0, 0);
    drive(0, 0, 4'b0001, 1, 0, 'h1FF);
    run(3, 0, 4'b0001);

    // Reset during a stall with a redirect pending.
    drive(1, 0, 4'b1111, 0, 0, 0);
    run(3, 0, 4'b1111);
    drive(0, 1, 4'b1111, 1, 1, 'h055);
    drive(1, 1, 4'b1111, 1, 3, 'h0AA);
    run(3, 0, 4'b1111);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 63) == 0),
            ($urandom_range(0, 3) == 0),
            NT'($urandom_range(0, 15)),
            ($urandom_range(0, 3) == 0),
            int'($urandom_range(0, NT - 1)),
            int'($urandom_range(0, (1 << AW) - 1)));
    end

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
